// File: rtl/dispatch_allocator_if.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_allocator_if
//  Description : Decode, dispatch, ROB-read, CDB, commit and LSQ signals of
//                the rename/dispatch stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface dispatch_allocator_if #(
    parameter int NUM_REGS = 32,
    parameter int ROB_SIZE = 16,
    parameter int LSQ_SIZE = 8,
    parameter int RS_SIZE  = 8,
    parameter int NUM_CDB  = 2,
    parameter int XLEN     = 32,
    parameter int COLOR_W  = 4
);
    localparam int c_RW = $clog2(NUM_REGS);
    localparam int c_TW = $clog2(ROB_SIZE + 1);
    localparam int c_LW = $clog2(LSQ_SIZE);
    localparam int c_SW = $clog2(RS_SIZE);

    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [c_RW-1:0]          in_rd;
    logic [c_RW-1:0]          in_rs1;
    logic [c_RW-1:0]          in_rs2;
    logic [XLEN-1:0]          in_rs1_val;
    logic [XLEN-1:0]          in_rs2_val;
    logic                     in_use_rs2;
    logic                     in_writes_rd;
    logic                     in_is_load;
    logic                     in_is_store;
    logic                     in_bypass_rs;
    logic [RS_SIZE-1:0]       rs_busy;
    logic [c_TW-1:0]          rob_raddr1;
    logic [c_TW-1:0]          rob_raddr2;
    logic [XLEN-1:0]          rob_rdata1;
    logic [XLEN-1:0]          rob_rdata2;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*c_TW-1:0]  cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_value;
    logic                     commit_valid;
    logic [c_RW-1:0]          commit_rd;
    logic [c_TW-1:0]          commit_tag;
    logic                     lsq_release;
    logic                     out_valid;
    logic                     out_ready;
    logic [c_TW-1:0]          out_tag;
    logic [XLEN-1:0]          out_val1;
    logic [XLEN-1:0]          out_val2;
    logic [c_TW-1:0]          out_tag1;
    logic [c_TW-1:0]          out_tag2;
    logic [c_SW-1:0]          out_rs_id;
    logic                     out_bypass_rs;
    logic [c_LW-1:0]          out_lsq_idx;
    logic [COLOR_W-1:0]       out_color;
    logic                     rob_full;
    logic                     lsq_full;

    modport slave (
        input  flush, in_valid, in_rd, in_rs1, in_rs2, in_rs1_val, in_rs2_val,
               in_use_rs2, in_writes_rd, in_is_load, in_is_store, in_bypass_rs,
               rs_busy, rob_rdata1, rob_rdata2, cdb_valid, cdb_tag, cdb_value,
               commit_valid, commit_rd, commit_tag, lsq_release, out_ready,
        output in_ready, rob_raddr1, rob_raddr2, out_valid, out_tag, out_val1,
               out_val2, out_tag1, out_tag2, out_rs_id, out_bypass_rs,
               out_lsq_idx, out_color, rob_full, lsq_full
    );

    modport master (
        output flush, in_valid, in_rd, in_rs1, in_rs2, in_rs1_val, in_rs2_val,
               in_use_rs2, in_writes_rd, in_is_load, in_is_store, in_bypass_rs,
               rs_busy, rob_rdata1, rob_rdata2, cdb_valid, cdb_tag, cdb_value,
               commit_valid, commit_rd, commit_tag, lsq_release, out_ready,
        input  in_ready, rob_raddr1, rob_raddr2, out_valid, out_tag, out_val1,
               out_val2, out_tag1, out_tag2, out_rs_id, out_bypass_rs,
               out_lsq_idx, out_color, rob_full, lsq_full
    );
endinterface
`default_nettype wire

// File: rtl/dispatch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_allocator
//  Description : Rename/dispatch stage: map table, ROB/LSQ allocation, RS pick
//                and operand resolution into a registered dispatch packet.
//  Revision    : 1.0  initial release
// ============================================================================
module dispatch_allocator #(
    parameter int NUM_REGS = 32,
    parameter int ROB_SIZE = 16,
    parameter int LSQ_SIZE = 8,
    parameter int RS_SIZE  = 8,
    parameter int NUM_CDB  = 2,
    parameter int XLEN     = 32,
    parameter int COLOR_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dispatch_allocator_if.slave  bus
);
    localparam int c_RW = $clog2(NUM_REGS);
    localparam int c_TW = $clog2(ROB_SIZE + 1);
    localparam int c_LW = $clog2(LSQ_SIZE);
    localparam int c_SW = $clog2(RS_SIZE);

    localparam logic [c_TW-1:0]    c_TAG_ONE   = c_TW'(1);
    localparam logic [c_TW-1:0]    c_ROB_MAX   = c_TW'(ROB_SIZE);
    localparam logic [c_LW:0]      c_LCNT_ONE  = (c_LW + 1)'(1);
    localparam logic [c_LW:0]      c_LSQ_MAX   = (c_LW + 1)'(LSQ_SIZE);
    localparam logic [c_LW-1:0]    c_LIDX_ONE  = c_LW'(1);
    localparam logic [c_LW-1:0]    c_LIDX_LAST = c_LW'(LSQ_SIZE - 1);
    localparam logic [COLOR_W-1:0] c_COLOR_ONE = COLOR_W'(1);

    logic [c_TW-1:0]    r_map_tag [NUM_REGS];
    logic [NUM_REGS-1:0] r_map_ready;
    logic [c_TW-1:0]    r_rob_tail;
    logic [c_TW-1:0]    r_rob_count;
    logic [c_LW-1:0]    r_lsq_tail;
    logic [c_LW:0]      r_lsq_count;
    logic [COLOR_W-1:0] r_color;

    logic               r_out_valid;
    logic [c_TW-1:0]    r_out_tag;
    logic [XLEN-1:0]    r_out_val1;
    logic [XLEN-1:0]    r_out_val2;
    logic [c_TW-1:0]    r_out_tag1;
    logic [c_TW-1:0]    r_out_tag2;
    logic [c_SW-1:0]    r_out_rs_id;
    logic               r_out_bypass_rs;
    logic [c_LW-1:0]    r_out_lsq_idx;
    logic [COLOR_W-1:0] r_out_color;

    logic               w_mem;
    logic               w_rob_full;
    logic               w_lsq_full;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_mem_accept;
    logic [c_TW-1:0]    w_map_tag1;
    logic [c_TW-1:0]    w_map_tag2;
    logic               w_cdb_hit1;
    logic               w_cdb_hit2;
    logic [XLEN-1:0]    w_cdb_val1;
    logic [XLEN-1:0]    w_cdb_val2;
    logic               w_hold_hit1;
    logic               w_hold_hit2;
    logic [XLEN-1:0]    w_hold_val1;
    logic [XLEN-1:0]    w_hold_val2;
    logic [XLEN-1:0]    w_src_val1;
    logic [XLEN-1:0]    w_src_val2;
    logic [c_TW-1:0]    w_src_tag1;
    logic [c_TW-1:0]    w_src_tag2;
    logic [c_SW-1:0]    w_rs_id;
    logic [NUM_REGS-1:0] w_map_cdb_hit;

    // Lowest-numbered matching channel supplies the value; tag 0 never matches.
    function automatic void cdb_lookup(
        input  logic [c_TW-1:0]         tag,
        input  logic [NUM_CDB-1:0]      valid,
        input  logic [NUM_CDB*c_TW-1:0] tags,
        input  logic [NUM_CDB*XLEN-1:0] vals,
        output logic                    hit,
        output logic [XLEN-1:0]         val
    );
        hit = 1'b0;
        val = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (valid[c] && (tag != '0) && (tags[c*c_TW +: c_TW] == tag)) begin
                hit = 1'b1;
                val = vals[c*XLEN +: XLEN];
            end
        end
    endfunction

    assign w_mem        = bus.in_is_load | bus.in_is_store;
    assign w_rob_full   = (r_rob_count == c_ROB_MAX);
    assign w_lsq_full   = (r_lsq_count == c_LSQ_MAX);
    assign w_in_ready   = !bus.flush && !w_rob_full && !(w_mem && w_lsq_full) &&
                          !(!bus.in_bypass_rs && (&bus.rs_busy)) &&
                          (!r_out_valid || bus.out_ready);
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_mem_accept = w_accept && w_mem;

    assign w_map_tag1     = r_map_tag[bus.in_rs1];
    assign w_map_tag2     = r_map_tag[bus.in_rs2];
    assign bus.rob_raddr1 = w_map_tag1;
    assign bus.rob_raddr2 = w_map_tag2;

    always_comb begin
        w_src_val1 = '0;
        w_src_tag1 = '0;
        w_src_val2 = '0;
        w_src_tag2 = '0;
        cdb_lookup(w_map_tag1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value, w_cdb_hit1, w_cdb_val1);
        cdb_lookup(w_map_tag2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value, w_cdb_hit2, w_cdb_val2);
        cdb_lookup(r_out_tag1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value, w_hold_hit1, w_hold_val1);
        cdb_lookup(r_out_tag2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value, w_hold_hit2, w_hold_val2);

        if (bus.in_rs1 == '0) begin
            w_src_val1 = '0;
        end else if (w_cdb_hit1) begin
            w_src_val1 = w_cdb_val1;
        end else if (r_map_ready[bus.in_rs1]) begin
            w_src_val1 = bus.rob_rdata1;
        end else if (w_map_tag1 == '0) begin
            w_src_val1 = bus.in_rs1_val;
        end else begin
            w_src_tag1 = w_map_tag1;
        end

        if (!bus.in_use_rs2 || (bus.in_rs2 == '0)) begin
            w_src_val2 = '0;
        end else if (w_cdb_hit2) begin
            w_src_val2 = w_cdb_val2;
        end else if (r_map_ready[bus.in_rs2]) begin
            w_src_val2 = bus.rob_rdata2;
        end else if (w_map_tag2 == '0) begin
            w_src_val2 = bus.in_rs2_val;
        end else begin
            w_src_tag2 = w_map_tag2;
        end
    end

    always_comb begin
        w_rs_id = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!bus.rs_busy[i]) begin
                w_rs_id = c_SW'(i);
            end
        end
        if (bus.in_bypass_rs) begin
            w_rs_id = '0;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_map_snoop
        logic [NUM_CDB-1:0] w_match;
        for (genvar c = 0; c < NUM_CDB; c++) begin : g_chan
            assign w_match[c] = bus.cdb_valid[c] && (r_map_tag[r] != '0) &&
                                (bus.cdb_tag[c*c_TW +: c_TW] == r_map_tag[r]);
        end
        assign w_map_cdb_hit[r] = |w_match;
    end

    // Later assignments win: dispatch rename over commit clear over CDB ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_map_tag[r] <= '0;
            end
            r_map_ready <= '0;
        end else if (bus.flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_map_tag[r] <= '0;
            end
            r_map_ready <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_map_cdb_hit[r]) begin
                    r_map_ready[r] <= 1'b1;
                end
            end
            if (bus.commit_valid && (r_map_tag[bus.commit_rd] == bus.commit_tag)) begin
                r_map_tag[bus.commit_rd]   <= '0;
                r_map_ready[bus.commit_rd] <= 1'b0;
            end
            if (w_accept && bus.in_writes_rd && (bus.in_rd != '0)) begin
                r_map_tag[bus.in_rd]   <= r_rob_tail;
                r_map_ready[bus.in_rd] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rob_tail  <= c_TAG_ONE;
            r_rob_count <= '0;
            r_lsq_tail  <= '0;
            r_lsq_count <= '0;
            r_color     <= '0;
        end else if (bus.flush) begin
            r_rob_tail  <= c_TAG_ONE;
            r_rob_count <= '0;
            r_lsq_tail  <= '0;
            r_lsq_count <= '0;
            r_color     <= '0;
        end else begin
            if (w_accept) begin
                r_rob_tail <= (r_rob_tail == c_ROB_MAX) ? c_TAG_ONE : r_rob_tail + c_TAG_ONE;
            end
            case ({w_accept, bus.commit_valid})
                2'b10:   r_rob_count <= r_rob_count + c_TAG_ONE;
                2'b01:   r_rob_count <= r_rob_count - c_TAG_ONE;
                default: r_rob_count <= r_rob_count;
            endcase
            if (w_mem_accept) begin
                r_lsq_tail <= (r_lsq_tail == c_LIDX_LAST) ? '0 : r_lsq_tail + c_LIDX_ONE;
            end
            case ({w_mem_accept, bus.lsq_release})
                2'b10:   r_lsq_count <= r_lsq_count + c_LCNT_ONE;
                2'b01:   r_lsq_count <= r_lsq_count - c_LCNT_ONE;
                default: r_lsq_count <= r_lsq_count;
            endcase
            if (w_accept && bus.in_is_store) begin
                r_color <= r_color + c_COLOR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid     <= 1'b0;
            r_out_tag       <= '0;
            r_out_val1      <= '0;
            r_out_val2      <= '0;
            r_out_tag1      <= '0;
            r_out_tag2      <= '0;
            r_out_rs_id     <= '0;
            r_out_bypass_rs <= 1'b0;
            r_out_lsq_idx   <= '0;
            r_out_color     <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid     <= 1'b1;
            r_out_tag       <= r_rob_tail;
            r_out_val1      <= w_src_val1;
            r_out_val2      <= w_src_val2;
            r_out_tag1      <= w_src_tag1;
            r_out_tag2      <= w_src_tag2;
            r_out_rs_id     <= w_rs_id;
            r_out_bypass_rs <= bus.in_bypass_rs;
            r_out_lsq_idx   <= r_lsq_tail;
            r_out_color     <= bus.in_is_store ? (r_color + c_COLOR_ONE) : r_color;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end else if (r_out_valid) begin
            // Stalled packet keeps listening for its outstanding operands.
            if (w_hold_hit1) begin
                r_out_val1 <= w_hold_val1;
                r_out_tag1 <= '0;
            end
            if (w_hold_hit2) begin
                r_out_val2 <= w_hold_val2;
                r_out_tag2 <= '0;
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.rob_full      = w_rob_full;
    assign bus.lsq_full      = w_lsq_full;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_tag       = r_out_tag;
    assign bus.out_val1      = r_out_val1;
    assign bus.out_val2      = r_out_val2;
    assign bus.out_tag1      = r_out_tag1;
    assign bus.out_tag2      = r_out_tag2;
    assign bus.out_rs_id     = r_out_rs_id;
    assign bus.out_bypass_rs = r_out_bypass_rs;
    assign bus.out_lsq_idx   = r_out_lsq_idx;
    assign bus.out_color     = r_out_color;
endmodule
`default_nettype wire

// File: tb/tb_dispatch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dispatch_allocator
//  Description : Directed self-checking bench for dispatch_allocator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dispatch_allocator;
    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    dispatch_allocator_if #(
        .NUM_REGS(32), .ROB_SIZE(16), .LSQ_SIZE(8), .RS_SIZE(8),
        .NUM_CDB(2), .XLEN(32), .COLOR_W(4)
    ) bus ();

    dispatch_allocator #(
        .NUM_REGS(32), .ROB_SIZE(16), .LSQ_SIZE(8), .RS_SIZE(8),
        .NUM_CDB(2), .XLEN(32), .COLOR_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ROB contents are a fixed pattern derived from the read address.
    assign bus.rob_rdata1 = 32'hB000_0000 | {27'd0, bus.rob_raddr1};
    assign bus.rob_rdata2 = 32'hC000_0000 | {27'd0, bus.rob_raddr2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_rd        = '0;
        bus.in_rs1       = '0;
        bus.in_rs2       = '0;
        bus.in_rs1_val   = '0;
        bus.in_rs2_val   = '0;
        bus.in_use_rs2   = 1'b1;
        bus.in_writes_rd = 1'b0;
        bus.in_is_load   = 1'b0;
        bus.in_is_store  = 1'b0;
        bus.in_bypass_rs = 1'b0;
        bus.rs_busy      = '0;
        bus.cdb_valid    = '0;
        bus.cdb_tag      = '0;
        bus.cdb_value    = '0;
        bus.commit_valid = 1'b0;
        bus.commit_rd    = '0;
        bus.commit_tag   = '0;
        bus.lsq_release  = 1'b0;
        bus.out_ready    = 1'b1;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic set_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] v1, input logic [31:0] v2, input logic use2,
                          input logic wr, input logic ld, input logic st, input logic byp);
        bus.in_valid     = 1'b1;
        bus.in_rd        = rd;
        bus.in_rs1       = rs1;
        bus.in_rs2       = rs2;
        bus.in_rs1_val   = v1;
        bus.in_rs2_val   = v2;
        bus.in_use_rs2   = use2;
        bus.in_writes_rd = wr;
        bus.in_is_load   = ld;
        bus.in_is_store  = st;
        bus.in_bypass_rs = byp;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        tests++; if (bus.out_tag !== 5'd0) begin fails++; $display("FAIL reset_out_tag: got %0d want 0", bus.out_tag); end
        tests++; if (bus.rob_full !== 1'b0) begin fails++; $display("FAIL reset_rob_full: got %0b want 0", bus.rob_full); end
        tests++; if (bus.lsq_full !== 1'b0) begin fails++; $display("FAIL reset_lsq_full: got %0b want 0", bus.lsq_full); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
        for (int r = 0; r < 32; r++) begin
            bus.in_rs1 = 5'(r);
            #1;
            tests++; if (bus.rob_raddr1 !== 5'd0) begin fails++; $display("FAIL reset_map[%0d]: got %0d want 0", r, bus.rob_raddr1); end
        end
        bus.in_rs1 = '0;
    endtask

    task automatic test_rename();
        apply_reset();
        set_op(5'd3, 5'd1, 5'd2, 32'h11, 32'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd1) begin fails++; $display("FAIL rename_first_tag: got v=%0b tag=%0d want v=1 tag=1", bus.out_valid, bus.out_tag); end
        tests++; if (bus.out_val1 !== 32'h11 || bus.out_val2 !== 32'h22) begin fails++; $display("FAIL rename_rf_vals: got %h %h want 11 22", bus.out_val1, bus.out_val2); end
        tests++; if (bus.out_tag1 !== 5'd0 || bus.out_tag2 !== 5'd0) begin fails++; $display("FAIL rename_rf_tags: got %0d %0d want 0 0", bus.out_tag1, bus.out_tag2); end
        set_op(5'd4, 5'd3, 5'd3, 32'h99, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        tests++; if (bus.rob_raddr1 !== 5'd1) begin fails++; $display("FAIL rename_map3: got %0d want 1", bus.rob_raddr1); end
        step();
        tests++; if (bus.out_tag !== 5'd2 || bus.out_tag1 !== 5'd1 || bus.out_tag2 !== 5'd1) begin fails++; $display("FAIL rename_dep_tags: got tag=%0d t1=%0d t2=%0d want 2 1 1", bus.out_tag, bus.out_tag1, bus.out_tag2); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.cdb_valid = 2'b10;
        bus.cdb_tag   = {5'd1, 5'd0};
        bus.cdb_value = {32'h55, 32'h0};
        step();
        bus.cdb_valid = '0;
        tests++; if (bus.out_valid !== 1'b1 || bus.out_tag1 !== 5'd0 || bus.out_tag2 !== 5'd0) begin fails++; $display("FAIL snoop_tags: got v=%0b t1=%0d t2=%0d want 1 0 0", bus.out_valid, bus.out_tag1, bus.out_tag2); end
        tests++; if (bus.out_val1 !== 32'h55 || bus.out_val2 !== 32'h55) begin fails++; $display("FAIL snoop_vals: got %h %h want 55 55", bus.out_val1, bus.out_val2); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %0b want 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL drain_out_valid: got %0b want 0", bus.out_valid); end
        set_op(5'd5, 5'd3, 5'd3, 32'h77, 32'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        tests++; if (bus.out_tag !== 5'd3 || bus.out_val1 !== 32'hB000_0001 || bus.out_tag1 !== 5'd0) begin fails++; $display("FAIL rob_ready_src: got tag=%0d v1=%h t1=%0d want 3 b0000001 0", bus.out_tag, bus.out_val1, bus.out_tag1); end
        tests++; if (bus.out_val2 !== 32'h0 || bus.out_tag2 !== 5'd0) begin fails++; $display("FAIL no_rs2: got %h t2=%0d want 0 0", bus.out_val2, bus.out_tag2); end
        bus.in_valid     = 1'b0;
        bus.commit_valid = 1'b1;
        bus.commit_rd    = 5'd3;
        bus.commit_tag   = 5'd1;
        step();
        bus.commit_rd  = 5'd5;
        bus.commit_tag = 5'd2;
        step();
        bus.commit_valid = 1'b0;
        bus.in_rs1 = 5'd3;
        bus.in_rs2 = 5'd5;
        #1;
        tests++; if (bus.rob_raddr1 !== 5'd0) begin fails++; $display("FAIL commit_clear: got %0d want 0", bus.rob_raddr1); end
        tests++; if (bus.rob_raddr2 !== 5'd3) begin fails++; $display("FAIL commit_keep: got %0d want 3", bus.rob_raddr2); end
    endtask

    task automatic test_cdb_priority();
        apply_reset();
        set_op(5'd7, 5'd1, 5'd2, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        set_op(5'd8, 5'd7, 5'd7, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {5'd1, 5'd1};
        bus.cdb_value = {32'hBB, 32'hAA};
        step();
        bus.in_valid  = 1'b0;
        bus.cdb_valid = '0;
        tests++; if (bus.out_val1 !== 32'hAA || bus.out_val2 !== 32'hAA || bus.out_tag1 !== 5'd0 || bus.out_tag2 !== 5'd0) begin fails++; $display("FAIL cdb_lowest: got %h %h t=%0d %0d want aa aa 0 0", bus.out_val1, bus.out_val2, bus.out_tag1, bus.out_tag2); end
    endtask

    task automatic test_rob_full();
        apply_reset();
        set_op(5'd0, 5'd1, 5'd2, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (16) step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd16) begin fails++; $display("FAIL rob_fill_tag: got v=%0b tag=%0d want 1 16", bus.out_valid, bus.out_tag); end
        tests++; if (bus.rob_full !== 1'b1 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL rob_full: got full=%0b rdy=%0b want 1 0", bus.rob_full, bus.in_ready); end
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rob_full_stall: got %0b want 0", bus.out_valid); end
        bus.in_valid     = 1'b0;
        bus.commit_valid = 1'b1;
        bus.commit_tag   = 5'd1;
        step();
        bus.commit_valid = 1'b0;
        tests++; if (bus.rob_full !== 1'b0) begin fails++; $display("FAIL rob_after_commit: got %0b want 0", bus.rob_full); end
        bus.in_valid     = 1'b1;
        bus.commit_valid = 1'b1;
        bus.commit_tag   = 5'd2;
        step();
        bus.commit_valid = 1'b0;
        tests++; if (bus.out_tag !== 5'd1 || bus.rob_full !== 1'b0) begin fails++; $display("FAIL rob_wrap_same_cycle: got tag=%0d full=%0b want 1 0", bus.out_tag, bus.rob_full); end
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.out_tag !== 5'd2 || bus.rob_full !== 1'b1) begin fails++; $display("FAIL rob_refill: got tag=%0d full=%0b want 2 1", bus.out_tag, bus.rob_full); end
    endtask

    task automatic test_lsq();
        apply_reset();
        set_op(5'd0, 5'd1, 5'd2, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        tests++; if (bus.out_lsq_idx !== 3'd0 || bus.out_color !== 4'd1) begin fails++; $display("FAIL store0: got idx=%0d col=%0d want 0 1", bus.out_lsq_idx, bus.out_color); end
        step();
        tests++; if (bus.out_lsq_idx !== 3'd1 || bus.out_color !== 4'd2) begin fails++; $display("FAIL store1: got idx=%0d col=%0d want 1 2", bus.out_lsq_idx, bus.out_color); end
        set_op(5'd6, 5'd1, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        tests++; if (bus.out_lsq_idx !== 3'd2 || bus.out_color !== 4'd2) begin fails++; $display("FAIL load0: got idx=%0d col=%0d want 2 2", bus.out_lsq_idx, bus.out_color); end
        repeat (5) step();
        tests++; if (bus.out_lsq_idx !== 3'd7 || bus.out_color !== 4'd2 || bus.lsq_full !== 1'b1) begin fails++; $display("FAIL lsq_fill: got idx=%0d col=%0d full=%0b want 7 2 1", bus.out_lsq_idx, bus.out_color, bus.lsq_full); end
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL lsq_full_load: got rdy=%0b want 0", bus.in_ready); end
        bus.in_is_load = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL lsq_full_alu: got rdy=%0b want 1", bus.in_ready); end
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd9) begin fails++; $display("FAIL lsq_alu_dispatch: got v=%0b tag=%0d want 1 9", bus.out_valid, bus.out_tag); end
        bus.in_valid    = 1'b0;
        bus.lsq_release = 1'b1;
        step();
        bus.lsq_release = 1'b0;
        tests++; if (bus.lsq_full !== 1'b0) begin fails++; $display("FAIL lsq_release: got %0b want 0", bus.lsq_full); end
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b1;
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.out_lsq_idx !== 3'd0 || bus.lsq_full !== 1'b1) begin fails++; $display("FAIL lsq_wrap: got idx=%0d full=%0b want 0 1", bus.out_lsq_idx, bus.lsq_full); end
    endtask

    task automatic test_rs_select();
        apply_reset();
        set_op(5'd0, 5'd1, 5'd2, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.rs_busy = 8'hFF;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rs_full_stall: got rdy=%0b want 0", bus.in_ready); end
        bus.rs_busy = 8'hF7;
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_rs_id !== 3'd3 || bus.out_bypass_rs !== 1'b0) begin fails++; $display("FAIL rs_pick: got v=%0b id=%0d byp=%0b want 1 3 0", bus.out_valid, bus.out_rs_id, bus.out_bypass_rs); end
        bus.rs_busy      = 8'hFF;
        bus.in_bypass_rs = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bypass_ready: got rdy=%0b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.out_bypass_rs !== 1'b1 || bus.out_rs_id !== 3'd0 || bus.out_tag !== 5'd2) begin fails++; $display("FAIL bypass_pkt: got byp=%0b id=%0d tag=%0d want 1 0 2", bus.out_bypass_rs, bus.out_rs_id, bus.out_tag); end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            set_op(5'(i), 5'd1, 5'd2, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, (i % 2) == 1, 1'b0);
            step();
        end
        bus.flush = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %0b want 0", bus.in_ready); end
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %0b want 0", bus.out_valid); end
        for (int r = 1; r <= 6; r++) begin
            bus.in_rs1 = 5'(r);
            #1;
            tests++; if (bus.rob_raddr1 !== 5'd0) begin fails++; $display("FAIL flush_map[%0d]: got %0d want 0", r, bus.rob_raddr1); end
        end
        set_op(5'd0, 5'd1, 5'd2, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.out_tag !== 5'd1 || bus.out_lsq_idx !== 3'd0 || bus.out_color !== 4'd1) begin fails++; $display("FAIL flush_restart: got tag=%0d idx=%0d col=%0d want 1 0 1", bus.out_tag, bus.out_lsq_idx, bus.out_color); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_op(5'd9, 5'd1, 5'd2, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        bus.in_rs1   = 5'd9;
        #1;
        tests++; if (bus.out_valid !== 1'b1 || bus.rob_raddr1 !== 5'd1) begin fails++; $display("FAIL pre_async: got v=%0b map=%0d want 1 1", bus.out_valid, bus.rob_raddr1); end
        #1;
        reset = 1'b1;
        #1;
        tests++; if (bus.out_valid !== 1'b0 || bus.rob_raddr1 !== 5'd0) begin fails++; $display("FAIL async_reset: got v=%0b map=%0d want 0 0", bus.out_valid, bus.rob_raddr1); end
        #1;
        reset = 1'b0;
        bus.in_rs1 = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_rename();
        test_cdb_priority();
        test_rob_full();
        test_lsq();
        test_rs_select();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
